uart_rx_frame: RTL and testbench

- Asynchronous serial receiver for the host-to-FPGA UART line (uart_txd_in at the top level).
- Receives 8N1 frames LSB-first and delivers each byte through a one-entry valid/ready holding register to the MicroBlaze-side glue logic.
- Uses 16x oversampling from an internal baud-tick divider.
- Reports framing errors, overrun and, when enabled, parity errors.

---
 rtl/uart_rx_frame.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 16x oversampled UART receiver with a one-entry valid/ready
// holding register. Frames are start + NB_DATA data bits (LSB first) + stop.
// Optional parity bit between data and stop: define UART_RX_PARITY_EN.
module uart_rx_frame #(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD       = 115200,
   parameter int NB_DATA    = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic               clock,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic               i_ready,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_valid,
   output logic               o_busy,
   output logic               o_frame_err,
   output logic               o_overrun,
   output logic               o_parity_err
);

   // Rounded clocks per oversample tick.
   localparam int DIV = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [3:0]    LAST_BIT = 4'(NB_DATA - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_STOP  = 3'd3;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
   localparam logic       PAR_ODD   = (PARITY_ODD != 0);
`endif

   // Reject configurations the datapath is not built for.
   if (NB_DATA < 5 || NB_DATA > 8 || PARITY_ODD < 0 || PARITY_ODD > 1 || DIV < 1) begin : g_bad_cfg
      $error("uart_rx_frame: unsupported NB_DATA/PARITY_ODD/baud configuration");
   end

   logic [2:0]         state_q, state_d;
   logic               rx_m_q, rx_m_d, rx_s_q, rx_s_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [3:0]         smp_q, smp_d;
   logic [3:0]         bit_q, bit_d;
   logic [NB_DATA-1:0] sh_q, sh_d;
   logic               good_q, good_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic               valid_q, valid_d;
   logic               ferr_q, ferr_d;
   logic               ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
   logic               par_q, par_d;
   logic               perr_q, perr_d;
   logic               par_bad;
   assign par_bad = (par_q != ((^sh_q) ^ PAR_ODD));
`endif

   logic tick, mid, last_bit;
   assign tick     = (cnt_q == DIV_LAST);
   // Mid start bit is 8 ticks in; every later bit is sampled 16 ticks on.
   assign mid      = tick && (smp_q == ((state_q == ST_START) ? 4'd7 : 4'd15));
   assign last_bit = (bit_q == LAST_BIT);

   // State register.
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state: walk start/data/(parity)/stop on the mid-bit samples.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!rx_s_q) state_d = ST_START;
         ST_START: if (mid) state_d = rx_s_q ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
         ST_DATA:   if (mid && last_bit) state_d = ST_PARITY;
         ST_PARITY: if (mid) state_d = ST_STOP;
`else
         ST_DATA:  if (mid && last_bit) state_d = ST_STOP;
`endif
         // Leave on the stop midpoint so a back-to-back start edge is caught.
         ST_STOP:  if (mid) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath registers: synchronizer, counters, shifter, holding register, pulses.
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         rx_m_q  <= 1'b1;
         rx_s_q  <= 1'b1;
         cnt_q   <= '0;
         smp_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         good_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         rx_m_q  <= rx_m_d;
         rx_s_q  <= rx_s_d;
         cnt_q   <= cnt_d;
         smp_q   <= smp_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         good_q  <= good_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   // Output/datapath logic driven by the current state.
   always_comb begin
      rx_m_d  = i_rx;
      rx_s_d  = rx_m_q;
      cnt_d   = '0;
      smp_d   = smp_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      good_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
      data_d  = data_q;
      valid_d = valid_q;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      // Divider idles at 0, so entering START starts a fresh tick phase.
      if (state_q != ST_IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;

      case (state_q)
         ST_IDLE: smp_d = '0;
         ST_START: begin
            if (mid) begin
               smp_d = '0;
               bit_d = '0;
            end else if (tick) begin
               smp_d = smp_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (tick) smp_d = smp_q + 1'b1;
            if (mid) begin
               sh_d  = {rx_s_q, sh_q[NB_DATA-1:1]};
               bit_d = bit_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) smp_d = smp_q + 1'b1;
            if (mid)  par_d = rx_s_q;
         end
`endif
         ST_STOP: begin
            if (tick) smp_d = smp_q + 1'b1;
            if (mid) begin
               if (!rx_s_q) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
               else if (par_bad) perr_d = 1'b1;
`endif
               else good_d = 1'b1;
            end
         end
         default: ;
      endcase

      // Holding register: a load in the same cycle as a read keeps o_valid high.
      if (valid_q && i_ready) valid_d = 1'b0;
      if (good_q) begin
         if (!valid_q || i_ready) begin
            data_d  = sh_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = perr_q;
`else
   assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomized bench for uart_rx_frame: frames are driven bit by bit and the
// outcome (delivered bytes, error/overrun pulse counts) is predicted by a
// frame-level model of the receiver and its one-entry holding register.
`timescale 1ns/1ps
module tb_uart_rx_frame;
   localparam int CLK_FREQ = 3200000;
   localparam int BAUD     = 100000;
   localparam int NB       = 8;
   localparam int PODD     = 0;
   localparam int BITC     = 32;   // clocks per bit
`ifdef UART_RX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_rx = 1'b1;
   logic          i_ready = 1'b1;
   logic [NB-1:0] o_data;
   logic          o_valid, o_busy, o_frame_err, o_overrun, o_parity_err;

   uart_rx_frame #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NB_DATA(NB), .PARITY_ODD(PODD)) dut (
      .clock(clock), .i_reset(i_reset), .i_rx(i_rx), .i_ready(i_ready),
      .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy),
      .o_frame_err(o_frame_err), .o_overrun(o_overrun), .o_parity_err(o_parity_err));

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: observes outputs on the falling edge, only ever accumulates.
   logic [7:0] got_q[$];
   int ferr_n = 0, ovr_n = 0, perr_n = 0, vcyc_n = 0, busy_n = 0, long_n = 0, excl_n = 0;
   logic pf = 1'b0, po = 1'b0, pp = 1'b0;
   always @(negedge clock) begin
      if (!i_reset) begin
         if (o_valid && i_ready) got_q.push_back(o_data);
         if (o_valid)      vcyc_n <= vcyc_n + 1;
         if (o_busy)       busy_n <= busy_n + 1;
         if (o_frame_err)  ferr_n <= ferr_n + 1;
         if (o_overrun)    ovr_n  <= ovr_n + 1;
         if (o_parity_err) perr_n <= perr_n + 1;
         if ((o_frame_err && pf) || (o_overrun && po) || (o_parity_err && pp)) long_n <= long_n + 1;
         if (int'(o_frame_err) + int'(o_overrun) + int'(o_parity_err) > 1) excl_n <= excl_n + 1;
      end
      pf <= o_frame_err;
      po <= o_overrun;
      pp <= o_parity_err;
   end

   // Frame-level reference model.
   logic [7:0] exp_q[$];
   logic [7:0] m_hold = '0;
   bit         m_full = 1'b0;
   int         e_ferr = 0, e_ovr = 0, e_perr = 0, vi = 0;

   task automatic model(input logic [7:0] d, input logic stop, input logic pflip, input logic rdy);
      if (rdy && m_full) begin exp_q.push_back(m_hold); m_full = 1'b0; end
      if (!stop)                 e_ferr++;
      else if (PAR_EN && pflip)  e_perr++;
      else if (m_full)           e_ovr++;
      else if (rdy)              exp_q.push_back(d);
      else begin m_hold = d; m_full = 1'b1; end
   endtask

   task automatic tickc();
      @(posedge clock); #1;
   endtask

   task automatic put_bit(input logic b, input int n);
      i_rx = b;
      repeat (n) tickc();
   endtask

   task automatic frame(input logic [7:0] d, input logic stop, input logic pflip, input logic rdy);
      i_ready = rdy;
      model(d, stop, pflip, rdy);
      put_bit(1'b0, BITC);
      for (int i = 0; i < NB; i++) put_bit(d[i], BITC);
      if (PAR_EN) put_bit((^d) ^ (PODD != 0) ^ pflip, BITC);
      put_bit(stop, BITC);
      i_rx = 1'b1;
      // A low stop bit looks like a new start edge: let it die as a false start.
      if (!stop) put_bit(1'b1, 2 * BITC);
   endtask

   task automatic verify(input string tag);
      check({tag, ":ferr"}, ferr_n, e_ferr);
      check({tag, ":ovr"},  ovr_n,  e_ovr);
      check({tag, ":perr"}, perr_n, e_perr);
      check({tag, ":nbytes"}, got_q.size(), exp_q.size());
      for (int i = vi; i < exp_q.size(); i++)
         check({tag, ":byte"}, (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF, exp_q[i]);
      vi = exp_q.size();
   endtask

   int v0, b0;

   initial begin
      repeat (3) tickc();
      check("rst_data", o_data, 0);
      check("rst_flags", {o_valid, o_busy, o_frame_err, o_overrun, o_parity_err}, 0);
      i_reset = 1'b0;
      repeat (4) tickc();

      // Single clean frame: one valid cycle, receiver idle by frame end.
      v0 = vcyc_n;
      frame(8'h55, 1'b1, 1'b0, 1'b1);
      check("x55_busy_end", o_busy, 0);
      put_bit(1'b1, 4);
      check("x55_vcyc", vcyc_n - v0, 1);
      verify("x55");

      // False start: 8 clocks low.
      v0 = vcyc_n; b0 = busy_n;
      put_bit(1'b0, 8);
      put_bit(1'b1, 2 * BITC);
      check("fs_busy_seen", (busy_n > b0), 1);
      check("fs_busy_end", o_busy, 0);
      check("fs_vcyc", vcyc_n - v0, 0);
      verify("fs");

      // Framing error then a good frame.
      frame(8'hA3, 1'b0, 1'b0, 1'b1);
      frame(8'h3C, 1'b1, 1'b0, 1'b1);
      put_bit(1'b1, 4);
      verify("ferr");

      // Back-to-back frames with the consumer stalled: second one overruns.
      frame(8'h12, 1'b1, 1'b0, 1'b0);
      frame(8'h34, 1'b1, 1'b0, 1'b0);
      put_bit(1'b1, 4);
      check("ovr_valid", o_valid, 1);
      check("ovr_data", o_data, 32'h12);
      verify("ovr");
      i_ready = 1'b1;
      exp_q.push_back(m_hold); m_full = 1'b0;
      tickc();
      i_ready = 1'b0;
      tickc();
      check("ovr_drain_valid", o_valid, 0);
      verify("drain");
      i_ready = 1'b1;

      // Reset in the middle of data bit 4 of 0xFF.
      put_bit(1'b0, BITC);
      put_bit(1'b1, 4 * BITC + 16);
      check("mrst_busy_pre", o_busy, 1);
      i_reset = 1'b1;
      tickc();
      check("mrst_flags", {o_valid, o_busy, o_frame_err, o_overrun, o_parity_err}, 0);
      check("mrst_data", o_data, 0);
      repeat (4) tickc();
      i_reset = 1'b0;
      m_full = 1'b0;
      repeat (4) tickc();
      frame(8'hC3, 1'b1, 1'b0, 1'b1);
      put_bit(1'b1, 4);
      verify("mrst");

`ifdef UART_RX_PARITY_EN
      frame(8'h07, 1'b1, 1'b0, 1'b1);
      frame(8'h07, 1'b1, 1'b1, 1'b1);
      put_bit(1'b1, 4);
      verify("par");
`endif

      // Random frames: data, stop errors, parity flips, stalled consumer, gaps.
      for (int n = 0; n < 24; n++) begin
         logic [7:0] d;
         logic st, pfl, rdy;
         d   = 8'($urandom);
         st  = ($urandom_range(0, 7) != 0);
         pfl = ($urandom_range(0, 4) == 0);
         rdy = $urandom_range(0, 1) != 0;
         frame(d, st, pfl, rdy);
         put_bit(1'b1, $urandom_range(0, 24));
      end
      i_ready = 1'b1;
      if (m_full) begin exp_q.push_back(m_hold); m_full = 1'b0; end
      repeat (4) tickc();
      verify("rand");
      check("pulse_width", long_n, 0);
      check("pulse_excl", excl_n, 0);
      check("end_idle", {o_valid, o_busy}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
